// File: rtl/phy_rx_deframer.sv
// phy_rx_deframer: rebuilds low-nibble-first bytes from the PHY stream and reports {len,len} plus error flags per frame.
// Optional RX_SFD_STRIP_EN adds a HUNT state that drops preamble nibbles up to the 0xD5 SFD.
module phy_rx_deframer #(
  parameter int MAX_LEN = 2048,
  parameter int MIN_LEN = 64
) (
  input  logic        clk_phy,
  input  logic        reset,
  input  logic [3:0]  phy_data_in,
  input  logic        phy_rx_en,
  output logic [7:0]  rx_data_out,
  output logic        rx_data_valid,
  output logic        rx_frame_start,
  output logic [23:0] rx_ctrl_out,
  output logic        rx_ctrl_valid,
  output logic [2:0]  rx_err,
  output logic [3:0]  rx_frame_seq
);
`ifdef RX_SFD_STRIP_EN
  typedef enum logic [1:0] {IDLE, RECV, DROP, HUNT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
`endif
  state_t state, state_n;
  logic [3:0] lo;
  logic [11:0] len;
  logic phase, ovf;
  logic lo_load, phase_set, byte_fire, ovf_fire, eof;
  always_comb begin
    state_n = state;
    lo_load = 1'b0;
    phase_set = 1'b0;
    byte_fire = 1'b0;
    ovf_fire = 1'b0;
    eof = 1'b0;
    case (state)
      IDLE: if (phy_rx_en) begin
        lo_load = 1'b1;
`ifdef RX_SFD_STRIP_EN
        state_n = HUNT;
`else
        phase_set = 1'b1;
        state_n = RECV;
`endif
      end
`ifdef RX_SFD_STRIP_EN
      // lo holds the previous preamble nibble; 5 then D marks the SFD
      HUNT: if (!phy_rx_en) state_n = IDLE;
        else if (lo == 4'h5 && phy_data_in == 4'hD) state_n = RECV;
        else lo_load = 1'b1;
`endif
      RECV: if (!phy_rx_en) begin
        eof = 1'b1;
        state_n = IDLE;
      end else if (!phase) begin
        lo_load = 1'b1;
        phase_set = 1'b1;
      end else if (len == 12'(MAX_LEN)) begin
        ovf_fire = 1'b1;
        state_n = DROP;
      end else byte_fire = 1'b1;
      DROP: if (!phy_rx_en) begin
        eof = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lo <= '0;
      len <= '0;
      phase <= 1'b0;
      ovf <= 1'b0;
      rx_data_out <= '0;
      rx_data_valid <= 1'b0;
      rx_frame_start <= 1'b0;
      rx_ctrl_out <= '0;
      rx_ctrl_valid <= 1'b0;
      rx_err <= '0;
      rx_frame_seq <= '0;
    end else begin
      state <= state_n;
      lo <= lo_load ? phy_data_in : lo;
      phase <= phase_set ? 1'b1 : (byte_fire || ovf_fire || eof) ? 1'b0 : phase;
      len <= eof ? 12'd0 : byte_fire ? len + 12'd1 : len;
      ovf <= eof ? 1'b0 : ovf_fire ? 1'b1 : ovf;
      rx_data_valid <= byte_fire;
      rx_frame_start <= byte_fire && len == 12'd0;
      rx_data_out <= byte_fire ? {phy_data_in, lo} : rx_data_out;
      rx_ctrl_valid <= eof;
      rx_ctrl_out <= eof ? {len, len} : rx_ctrl_out;
      rx_err <= eof ? {ovf, len < 12'(MIN_LEN), phase} : rx_err;
      rx_frame_seq <= eof ? rx_frame_seq + 4'd1 : rx_frame_seq;
    end
  end
endmodule
